// File: rtl/uart_pkg.sv
// Shared constants and FSM state types for the FIFO-buffered UART.
package uart_pkg;

  // Register byte offsets from BASE_ADDR
  localparam logic [31:0] OffTxd    = 32'h00;
  localparam logic [31:0] OffRxd    = 32'h04;
  localparam logic [31:0] OffStatus = 32'h08;
  localparam logic [31:0] OffCtrl   = 32'h0C;
  localparam logic [31:0] OffBaud   = 32'h10;

  // STATUS bit positions
  localparam int unsigned StTxEmpty   = 0;
  localparam int unsigned StTxFull    = 1;
  localparam int unsigned StRxEmpty   = 2;
  localparam int unsigned StRxFull    = 3;
  localparam int unsigned StRxOverrun = 4;
  localparam int unsigned StParityErr = 5;
  localparam int unsigned StFrameErr  = 6;
  localparam int unsigned StTxBusy    = 7;
  localparam int unsigned StTxDrop    = 8;

  // CTRL bit positions
  localparam int unsigned CtrlTxIrqEn   = 0;
  localparam int unsigned CtrlRxIrqEn   = 1;
  localparam int unsigned CtrlParityEn  = 2;
  localparam int unsigned CtrlParityOdd = 3;

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO; a pop frees a slot for a same-cycle push even when full.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FullCount);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/uart_fifo_unit.sv
// Memory-mapped UART with programmable baud, optional parity, TX/RX FIFOs and irq.
module uart_fifo_unit
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h40000018,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        out,
  input  logic        in,
  output logic        irq
);
  localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

  logic sel_txd, sel_rxd, sel_status, sel_ctrl, sel_baud;
  assign sel_txd    = (addr == BASE_ADDR + OffTxd);
  assign sel_rxd    = (addr == BASE_ADDR + OffRxd);
  assign sel_status = (addr == BASE_ADDR + OffStatus);
  assign sel_ctrl   = (addr == BASE_ADDR + OffCtrl);
  assign sel_baud   = (addr == BASE_ADDR + OffBaud);

  logic [3:0]  ctrl_q;
  logic [15:0] baud_q, div_cnt_q;
  logic        tick, irq_q;
  logic        rx_overrun_q, parity_err_q, frame_err_q, tx_drop_q;
  logic        rx_overrun_ev, parity_err_ev, frame_err_ev, tx_drop_ev;
  logic        stat_clr;
  logic [8:0]  status;

  logic                 tx_push, tx_pop, tx_full, tx_empty, tx_busy, tx_load;
  logic [DATA_BITS-1:0] tx_head;
  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_BITS-1:0] rx_head;

  tx_state_e            tx_state_q, tx_state_d;
  logic [3:0]           tx_phase_q, tx_phase_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;

  rx_state_e            rx_state_q, rx_state_d;
  logic [3:0]           rx_phase_q, rx_phase_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [1:0]           sync_q;
  logic                 rx_prev_q, rx_s;

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:16];

  assign tick       = (div_cnt_q == 16'd0);
  assign tx_push    = wr & sel_txd;
  assign rx_pop     = rd & sel_rxd;
  assign stat_clr   = rd & sel_status;
  assign tx_busy    = (tx_state_q != TxIdle);
  assign tx_drop_ev    = tx_push & tx_full & ~tx_pop;
  assign rx_overrun_ev = rx_push & rx_full & ~rx_pop;
  assign rx_s       = sync_q[1];
  assign irq        = irq_q;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .wdata(wdata[DATA_BITS-1:0]), .pop(tx_pop),
    .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .wdata(rx_shift_q), .pop(rx_pop),
    .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // Status word assembly
  always_comb begin
    status              = '0;
    status[StTxEmpty]   = tx_empty;
    status[StTxFull]    = tx_full;
    status[StRxEmpty]   = rx_empty;
    status[StRxFull]    = rx_full;
    status[StRxOverrun] = rx_overrun_q;
    status[StParityErr] = parity_err_q;
    status[StFrameErr]  = frame_err_q;
    status[StTxBusy]    = tx_busy;
    status[StTxDrop]    = tx_drop_q;
  end

  // Combinational read mux; an empty RXD reads as zero
  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_rxd && !rx_empty) rdata = 32'(rx_head);
      else if (sel_status)      rdata = {23'd0, status};
      else if (sel_ctrl)        rdata = {28'd0, ctrl_q};
      else if (sel_baud)        rdata = {16'd0, baud_q};
    end
  end

  // Config registers, baud divider, sticky flags, synchroniser and irq
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q       <= '0;
      baud_q       <= DEFAULT_DIV;
      div_cnt_q    <= DEFAULT_DIV;
      rx_overrun_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      tx_drop_q    <= 1'b0;
      sync_q       <= 2'b11;
      rx_prev_q    <= 1'b1;
      irq_q        <= 1'b0;
    end else begin
      if (wr && sel_ctrl) ctrl_q <= wdata[3:0];
      if (wr && sel_baud) baud_q <= wdata[15:0];
      div_cnt_q    <= tick ? baud_q : div_cnt_q - 16'd1;
      // A same-cycle event wins over the read clear
      rx_overrun_q <= (rx_overrun_q & ~stat_clr) | rx_overrun_ev;
      parity_err_q <= (parity_err_q & ~stat_clr) | parity_err_ev;
      frame_err_q  <= (frame_err_q & ~stat_clr) | frame_err_ev;
      tx_drop_q    <= (tx_drop_q & ~stat_clr) | tx_drop_ev;
      sync_q       <= {sync_q[0], in};
      rx_prev_q    <= rx_s;
      irq_q        <= (ctrl_q[CtrlTxIrqEn] & tx_empty & ~tx_busy) |
                      (ctrl_q[CtrlRxIrqEn] & ~rx_empty);
    end
  end

  // TX FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_phase_q <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_phase_q <= tx_phase_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
    end
  end

  // TX next state; the stop bit chains straight into the next queued byte
  always_comb begin
    tx_state_d = tx_state_q;
    tx_phase_d = tx_phase_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_load    = 1'b0;
    tx_pop     = 1'b0;
    if (tick) begin
      if (tx_state_q == TxIdle) begin
        tx_load = ~tx_empty;
      end else begin
        tx_phase_d = tx_phase_q + 4'd1;
        if (tx_phase_q == 4'd15) begin
          case (tx_state_q)
            TxStart: begin
              tx_state_d = TxData;
              tx_bit_d   = '0;
            end
            TxData: begin
              tx_shift_d = tx_shift_q >> 1;
              tx_bit_d   = tx_bit_q + 3'd1;
              if (tx_bit_q == LastBit) tx_state_d = ctrl_q[CtrlParityEn] ? TxParity : TxStop;
            end
            TxParity: tx_state_d = TxStop;
            TxStop: begin
              if (!tx_empty) tx_load = 1'b1;
              else           tx_state_d = TxIdle;
            end
            default: tx_state_d = TxIdle;
          endcase
        end
      end
    end
    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_shift_d = tx_head;
      tx_par_d   = (^tx_head) ^ ctrl_q[CtrlParityOdd];
      tx_state_d = TxStart;
      tx_phase_d = '0;
    end
  end

  // Serial line decoded from state so reset forces it high immediately
  always_comb begin
    case (tx_state_q)
      TxStart:  out = 1'b0;
      TxData:   out = tx_shift_q[0];
      TxParity: out = tx_par_q;
      default:  out = 1'b1;
    endcase
  end

  // RX FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RxIdle;
      rx_phase_q <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_phase_q <= rx_phase_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // RX next state: start verified at tick 8, later bits sampled every 16 ticks
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_phase_d    = rx_phase_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_push       = 1'b0;
    parity_err_ev = 1'b0;
    frame_err_ev  = 1'b0;
    if (rx_state_q == RxIdle) begin
      if (rx_prev_q && !rx_s) begin
        rx_state_d = RxStart;
        rx_phase_d = '0;
      end
    end else if (tick) begin
      rx_phase_d = rx_phase_q + 4'd1;
      case (rx_state_q)
        RxStart: begin
          if (rx_phase_q == 4'd7) begin
            rx_phase_d = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_s ? RxIdle : RxData;
          end
        end
        RxData: begin
          if (rx_phase_q == 4'd15) begin
            rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == LastBit) rx_state_d = ctrl_q[CtrlParityEn] ? RxParity : RxStop;
          end
        end
        RxParity: begin
          if (rx_phase_q == 4'd15) begin
            parity_err_ev = rx_s ^ (^rx_shift_q) ^ ctrl_q[CtrlParityOdd];
            rx_state_d    = RxStop;
          end
        end
        RxStop: begin
          if (rx_phase_q == 4'd15) begin
            rx_state_d   = RxIdle;
            rx_push      = rx_s;
            frame_err_ev = ~rx_s;
          end
        end
        default: rx_state_d = RxIdle;
      endcase
    end
  end

endmodule
